// File: rtl/divmod_recombine_4bit_if.sv
`default_nettype none
// ============================================================================
//  Module      : divmod_recombine_4bit_if
//  Description : Operand/result bundle for the divider recombination checker.
//                The master drives start and operands; the slave returns
//                product, status and the match flag.
//  Revision    : 1.0 - initial release
// ============================================================================
interface divmod_recombine_4bit_if;
    logic       start;
    logic [3:0] Q_input;
    logic [3:0] B_input;
    logic [3:0] R_input;
    logic [3:0] A_check;
    logic [7:0] product;
    logic       busy;
    logic       done;
    logic       match;

    modport master (
        output start, Q_input, B_input, R_input, A_check,
        input  product, busy, done, match
    );

    modport slave (
        input  start, Q_input, B_input, R_input, A_check,
        output product, busy, done, match
    );
endinterface
`default_nettype wire

// File: rtl/divmod_recombine_4bit.sv
`default_nettype none
// ============================================================================
//  Module      : divmod_recombine_4bit
//  Description : Shift-add multiply-accumulate that rebuilds a dividend as
//                Q*B+R from a 4-bit divider's outputs, and flags whether the
//                rebuilt value equals the expected dividend.
//  Revision    : 1.0 - initial release
// ============================================================================
module divmod_recombine_4bit (
    input  wire logic                clk,
    input  wire logic                rst_n,
    divmod_recombine_4bit_if.slave   bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] C_LAST_ITER = 2'd3;

    logic [1:0] r_state;
    logic [7:0] r_mcand;
    logic [3:0] r_mplier;
    logic [7:0] r_acc;
    logic [3:0] r_chk;
    logic [1:0] r_cnt;
    logic [7:0] r_product;
    logic       r_done;
    logic       r_match;

    logic       w_accept;
    logic [7:0] w_acc_next;

    // A request is only honoured when no operation is in flight.
    assign w_accept   = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // One multiplier bit per iteration; the sum never exceeds 240 so 8 bits suffice.
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // Control FSM with datapath: latch operands, iterate 4 times, publish result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_mcand   <= 8'h00;
            r_mplier  <= 4'h0;
            r_acc     <= 8'h00;
            r_chk     <= 4'h0;
            r_cnt     <= 2'd0;
            r_product <= 8'h00;
            r_done    <= 1'b0;
            r_match   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_mcand  <= {4'b0000, bus.B_input};
                r_mplier <= bus.Q_input;
                r_acc    <= {4'b0000, bus.R_input};
                r_chk    <= bus.A_check;
                r_cnt    <= 2'd0;
                r_state  <= S_CALC;
            end else begin
                case (r_state)
                    S_CALC: begin
                        r_acc    <= w_acc_next;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + 2'd1;
                        // No early exit: latency stays fixed regardless of operands.
                        if (r_cnt == C_LAST_ITER) begin
                            r_state   <= S_DONE;
                            r_done    <= 1'b1;
                            r_product <= w_acc_next;
                            r_match   <= (w_acc_next == {4'b0000, r_chk});
                        end
                    end
                    S_DONE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.busy    = (r_state == S_CALC);
    assign bus.done    = r_done;
    assign bus.product = r_product;
    assign bus.match   = r_match;

endmodule
`default_nettype wire

// File: tb/tb_divmod_recombine_4bit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_divmod_recombine_4bit
//  Description : Self-checking bench for divmod_recombine_4bit. Expected
//                results are queued when a request is driven and compared
//                when done pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_divmod_recombine_4bit;

    typedef struct packed {
        logic [7:0] p;
        logic       m;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    logic prev_done;
    exp_t sb[$];

    divmod_recombine_4bit_if bus ();

    divmod_recombine_4bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Queue the expected outcome of an operation and present its operands.
    task automatic drive_op(input logic [3:0] q, input logic [3:0] b,
                            input logic [3:0] r, input logic [3:0] a);
        int   v;
        exp_t e;
        v          = int'(q) * int'(b) + int'(r);
        e.p        = v[7:0];
        e.m        = (v == int'(a));
        sb.push_back(e);
        bus.Q_input = q;
        bus.B_input = b;
        bus.R_input = r;
        bus.A_check = a;
        bus.start   = 1'b1;
    endtask

    // Scoreboard monitor: compare on each done pulse, plus handshake invariants.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_done = 1'b0;
        end else begin
            if (bus.done) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_done: product=%0d with no request pending", bus.product);
                end else begin
                    e = sb.pop_front();
                    if (bus.product !== e.p || bus.match !== e.m) begin
                        n_errors++;
                        $display("FAIL result: product=%0d match=%0b, required product=%0d match=%0b",
                                 bus.product, bus.match, e.p, e.m);
                    end
                end
            end
            n_checks++;
            if (bus.busy && bus.done) begin
                n_errors++;
                $display("FAIL busy_done_overlap: busy=%0b done=%0b, required not both high",
                         bus.busy, bus.done);
            end
            n_checks++;
            if (bus.done && prev_done) begin
                n_errors++;
                $display("FAIL done_consecutive: done high two cycles, required single pulse");
            end
            prev_done = bus.done;
        end
    end

    // Bounded wait until every queued expectation has been consumed.
    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL %s_timeout: %0d results outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.Q_input = 4'h0; bus.B_input = 4'h0; bus.R_input = 4'h0; bus.A_check = 4'h0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.product !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.match !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_values: product=%0d busy=%0b done=%0b match=%0b, required 0 0 0 0",
                     bus.product, bus.busy, bus.done, bus.match);
        end
        // start while in reset must not launch anything
        bus.start = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL start_in_reset: busy=%0b, required 0", bus.busy);
        end
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_after_reset: busy=%0b, required 0", bus.busy);
        end
    endtask

    task automatic test_basic();
        drive_op(4'd3, 4'd4, 4'd1, 4'd13);
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                n_errors++;
                $display("FAIL basic_busy[%0d]: busy=%0b done=%0b, required 1 0", i, bus.busy, bus.done);
            end
        end
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b1 || bus.product !== 8'd13 || bus.match !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_done: done=%0b product=%0d match=%0b, required 1 13 1",
                     bus.done, bus.product, bus.match);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.product !== 8'd13 || bus.match !== 1'b1 || bus.done !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_hold: product=%0d match=%0b done=%0b, required 13 1 0",
                     bus.product, bus.match, bus.done);
        end
    endtask

    task automatic test_max_and_zero();
        @(posedge clk); #1;
        drive_op(4'd15, 4'd15, 4'd15, 4'd0);
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (bus.product !== 8'hF0 || bus.match !== 1'b0) begin
            n_errors++;
            $display("FAIL max_value: product=%0d match=%0b, required 240 0", bus.product, bus.match);
        end
        @(posedge clk); #1;
        drive_op(4'd7, 4'd0, 4'd5, 4'd5);
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (bus.product !== 8'd5 || bus.match !== 1'b1) begin
            n_errors++;
            $display("FAIL div_by_zero: product=%0d match=%0b, required 5 1", bus.product, bus.match);
        end
        @(posedge clk); #1;
        drive_op(4'd0, 4'd9, 4'd0, 4'd0);
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (bus.product !== 8'd0) begin
            n_errors++;
            $display("FAIL zero_quotient: product=%0d, required 0", bus.product);
        end
        wait_drain("max_zero");
    endtask

    task automatic test_ignored_start();
        int dones;
        @(posedge clk); #1;
        drive_op(4'd2, 4'd3, 4'd0, 4'd6);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.Q_input = 4'd15; bus.B_input = 4'd15;
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        n_checks++;
        if (dones != 1 || bus.product !== 8'd6) begin
            n_errors++;
            $display("FAIL ignored_start: dones=%0d product=%0d, required 1 6", dones, bus.product);
        end
        wait_drain("ignored_start");
    endtask

    task automatic test_back_to_back();
        int dones;
        int last;
        int gap_err;
        @(posedge clk); #1;
        drive_op(4'd5, 4'd2, 4'd1, 4'd11);
        drive_op(4'd5, 4'd2, 4'd1, 4'd11);
        drive_op(4'd5, 4'd2, 4'd1, 4'd11);
        dones = 0; last = -1; gap_err = 0;
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            if (bus.done) begin
                if (last >= 0 && (c - last) != 5) gap_err++;
                last = c;
                dones++;
            end
            if (c == 14) bus.start = 1'b0;
        end
        n_checks++;
        if (dones != 3 || gap_err != 0) begin
            n_errors++;
            $display("FAIL back_to_back: dones=%0d bad_gaps=%0d, required 3 0", dones, gap_err);
        end
        wait_drain("back_to_back");
    endtask

    task automatic test_mid_reset();
        int dones;
        @(posedge clk); #1;
        drive_op(4'd6, 4'd6, 4'd0, 4'd0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        n_checks++;
        if (bus.product !== 8'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset: product=%0d busy=%0b done=%0b, required 0 0 0",
                     bus.product, bus.busy, bus.done);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        n_checks++;
        if (dones != 0) begin
            n_errors++;
            $display("FAIL aborted_done: dones=%0d, required 0", dones);
        end
        @(posedge clk); #1;
        drive_op(4'd1, 4'd1, 4'd1, 4'd2);
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b1 || bus.product !== 8'd2) begin
            n_errors++;
            $display("FAIL after_reset_op: done=%0b product=%0d, required 1 2", bus.done, bus.product);
        end
        wait_drain("mid_reset");
    endtask

    task automatic test_sweep();
        @(posedge clk); #1;
        for (int q = 0; q < 16; q++)
            for (int b = 0; b < 16; b++)
                for (int r = 0; r < 16; r++) begin
                    drive_op(4'(q), 4'(b), 4'(r), 4'((q * b + r) & 15));
                    @(posedge clk); #1;
                    bus.start = 1'b0;
                    repeat (4) @(posedge clk);
                    #1;
                end
        wait_drain("sweep");
    endtask

    task automatic test_divider_check();
        @(posedge clk); #1;
        for (int a = 0; a < 16; a++)
            for (int b = 1; b < 16; b++) begin
                drive_op(4'(a / b), 4'(b), 4'(a % b), 4'(a));
                @(posedge clk); #1;
                bus.start = 1'b0;
                repeat (4) @(posedge clk);
                #1;
            end
        wait_drain("divider_check");
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        prev_done = 1'b0;
        test_reset();
        test_basic();
        test_max_and_zero();
        test_ignored_start();
        test_back_to_back();
        test_mid_reset();
        test_sweep();
        test_divider_check();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard stop in case the run stalls.
    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation exceeded time limit, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
